demux_one_to_two_stream: RTL and testbench



---
 rtl/demux_one_to_two_stream_if.sv | 35 +++
 rtl/demux_one_to_two_stream.sv | 86 ++++++++
 tb/tb_demux_one_to_two_stream.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/demux_one_to_two_stream_if.sv
// rtl/demux_one_to_two_stream_if.sv - stream bundle for the 1:2 demux: one producer side, two sink sides
interface demux_one_to_two_stream_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
);
  logic [DATA_WIDTH-1:0]  in_data;
  logic                   in_select;
  logic                   in_valid;
  logic                   ou_ready;

  logic [DATA_WIDTH-1:0]  ou_data_one;
  logic                   ou_valid_one;
  logic                   in_ready_one;

  logic [DATA_WIDTH-1:0]  ou_data_two;
  logic                   ou_valid_two;
  logic                   in_ready_two;

  logic [COUNT_WIDTH-1:0] ou_count_one;
  logic [COUNT_WIDTH-1:0] ou_count_two;

  // Producer and sinks drive the in_* signals.
  modport master (
    output in_data, in_select, in_valid, in_ready_one, in_ready_two,
    input  ou_ready, ou_data_one, ou_valid_one, ou_data_two, ou_valid_two,
           ou_count_one, ou_count_two
  );

  // The demux drives the ou_* signals.
  modport slave (
    input  in_data, in_select, in_valid, in_ready_one, in_ready_two,
    output ou_ready, ou_data_one, ou_valid_one, ou_data_two, ou_valid_two,
           ou_count_one, ou_count_two
  );
endinterface

// File: rtl/demux_one_to_two_stream.sv
// rtl/demux_one_to_two_stream.sv - routes one valid/ready stream into two 2-deep output FIFOs
module demux_one_to_two_stream #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                        in_clk,
  input  logic                        in_reset_n,
  demux_one_to_two_stream_if.slave    bus
);
  // Index 0 is output one, index 1 is output two.
  logic [1:0][DATA_WIDTH-1:0]  head_q;
  logic [1:0][DATA_WIDTH-1:0]  tail_q;
  logic [1:0][1:0]             occ_q;
  logic [1:0][COUNT_WIDTH-1:0] cnt_q;

  logic [1:0] full;
  logic [1:0] valid;
  logic [1:0] ready;
  logic [1:0] push;
  logic [1:0] pop;
  logic       accept;

  assign ready[0] = bus.in_ready_one;
  assign ready[1] = bus.in_ready_two;

  always_comb begin
    full  = '0;
    valid = '0;
    pop   = '0;
    for (int i = 0; i < 2; i++) begin
      full[i]  = (occ_q[i] == 2'd2);
      valid[i] = (occ_q[i] != 2'd0);
      pop[i]   = valid[i] & ready[i];
    end
  end

  // Readiness looks only at the selected FIFO's fullness, never at the sinks.
  assign accept  = in_reset_n & (bus.in_select ? ~full[1] : ~full[0]);
  assign push[0] = bus.in_valid & accept & ~bus.in_select;
  assign push[1] = bus.in_valid & accept &  bus.in_select;

  always_ff @(posedge in_clk) begin
    if (!in_reset_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      cnt_q  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (pop[i]) begin
          cnt_q[i] <= cnt_q[i] + COUNT_WIDTH'(1);
        end
        // An emptied FIFO keeps its head register, so the last popped word stays visible.
        case ({push[i], pop[i]})
          2'b10: begin
            if (occ_q[i] == 2'd0) begin
              head_q[i] <= bus.in_data;
            end else begin
              tail_q[i] <= bus.in_data;
            end
            occ_q[i] <= occ_q[i] + 2'd1;
          end
          2'b01: begin
            if (occ_q[i] == 2'd2) begin
              head_q[i] <= tail_q[i];
            end
            occ_q[i] <= occ_q[i] - 2'd1;
          end
          2'b11: begin
            head_q[i] <= bus.in_data;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.ou_ready     = accept;
  assign bus.ou_data_one  = head_q[0];
  assign bus.ou_valid_one = valid[0];
  assign bus.ou_data_two  = head_q[1];
  assign bus.ou_valid_two = valid[1];
  assign bus.ou_count_one = cnt_q[0];
  assign bus.ou_count_two = cnt_q[1];
endmodule

// File: tb/tb_demux_one_to_two_stream.sv
// tb/tb_demux_one_to_two_stream.sv - self-checking bench for the 1:2 stream demux
module tb_demux_one_to_two_stream;
  localparam int DW = 32;
  localparam int CW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  demux_one_to_two_stream_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) bus ();

  demux_one_to_two_stream #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .in_clk     (clk),
    .in_reset_n (rst_n),
    .bus        (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per output plus the last word each sink received.
  logic [DW-1:0] q1[$];
  logic [DW-1:0] q2[$];
  logic [DW-1:0] last1 = '0;
  logic [DW-1:0] last2 = '0;
  int            c1 = 0;
  int            c2 = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [DW-1:0] d,
                       input logic r1, input logic r2);
    bus.in_valid     = v;
    bus.in_select    = s;
    bus.in_data      = d;
    bus.in_ready_one = r1;
    bus.in_ready_two = r2;
  endtask

  // Compare all outputs with the model, then advance one edge and update the model.
  task automatic cycle();
    logic exp_ready, do_push, do_pop1, do_pop2, sel;
    logic [DW-1:0] d;
    #1;
    exp_ready = rst_n && (bus.in_select ? (q2.size() < 2) : (q1.size() < 2));
    chk("ready", 64'(bus.ou_ready), 64'(exp_ready));
    chk("valid_one", 64'(bus.ou_valid_one), 64'(q1.size() > 0));
    chk("valid_two", 64'(bus.ou_valid_two), 64'(q2.size() > 0));
    chk("data_one", 64'(bus.ou_data_one), 64'((q1.size() > 0) ? q1[0] : last1));
    chk("data_two", 64'(bus.ou_data_two), 64'((q2.size() > 0) ? q2[0] : last2));
    chk("count_one", 64'(bus.ou_count_one), 64'(c1 % (1 << CW)));
    chk("count_two", 64'(bus.ou_count_two), 64'(c2 % (1 << CW)));
    do_pop1 = (q1.size() > 0) && bus.in_ready_one;
    do_pop2 = (q2.size() > 0) && bus.in_ready_two;
    do_push = bus.in_valid && exp_ready;
    sel     = bus.in_select;
    d       = bus.in_data;
    @(posedge clk);
    if (!rst_n) begin
      q1.delete();
      q2.delete();
      last1 = '0;
      last2 = '0;
      c1    = 0;
      c2    = 0;
    end else begin
      if (do_pop1) begin last1 = q1.pop_front(); c1++; end
      if (do_pop2) begin last2 = q2.pop_front(); c2++; end
      if (do_push) begin
        if (sel) q2.push_back(d);
        else     q1.push_back(d);
      end
    end
    #1;
  endtask

  initial begin
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    // Test 1: reset state, then a single word through output one.
    drive(1'b1, 1'b0, 32'h1234_5678, 1'b1, 1'b1);
    cycle();
    chk("rst_valid_one", 64'(bus.ou_valid_one), 64'd0);
    chk("rst_data_one", 64'(bus.ou_data_one), 64'd0);
    chk("rst_count_two", 64'(bus.ou_count_two), 64'd0);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 32'hAAAA_0001, 1'b1, 1'b0);
    cycle();
    chk("t1_valid_one", 64'(bus.ou_valid_one), 64'd1);
    chk("t1_data_one", 64'(bus.ou_data_one), 64'hAAAA_0001);
    chk("t1_valid_two", 64'(bus.ou_valid_two), 64'd0);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    cycle();
    chk("t1_count_one", 64'(bus.ou_count_one), 64'd1);

    // Test 2: stalled output two does not block output one.
    drive(1'b1, 1'b1, 32'h11, 1'b0, 1'b0); cycle();
    drive(1'b1, 1'b1, 32'h22, 1'b0, 1'b0); cycle();
    drive(1'b1, 1'b1, 32'h99, 1'b0, 1'b0);
    #1;
    chk("t2_ready_full", 64'(bus.ou_ready), 64'd0);
    cycle();
    drive(1'b1, 1'b0, 32'h33, 1'b1, 1'b0);
    #1;
    chk("t2_ready_one", 64'(bus.ou_ready), 64'd1);
    cycle();
    chk("t2_data_one", 64'(bus.ou_data_one), 64'h33);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
    chk("t2_first_two", 64'(bus.ou_data_two), 64'h11);
    cycle();
    chk("t2_second_two", 64'(bus.ou_data_two), 64'h22);
    cycle();
    chk("t2_count_two", 64'(bus.ou_count_two), 64'd2);

    // Test 3: full FIFO refuses the push even while popping.
    drive(1'b1, 1'b0, 32'h01, 1'b0, 1'b0); cycle();
    drive(1'b1, 1'b0, 32'h02, 1'b0, 1'b0); cycle();
    drive(1'b1, 1'b0, 32'h03, 1'b1, 1'b0);
    #1;
    chk("t3_refused", 64'(bus.ou_ready), 64'd0);
    chk("t3_head_01", 64'(bus.ou_data_one), 64'h01);
    cycle();
    chk("t3_head_02", 64'(bus.ou_data_one), 64'h02);
    #1;
    chk("t3_accepted", 64'(bus.ou_ready), 64'd1);
    cycle();
    chk("t3_head_03", 64'(bus.ou_data_one), 64'h03);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    cycle();

    // Test 4: push and pop together at occupancy one.
    drive(1'b1, 1'b0, 32'h55, 1'b0, 1'b0); cycle();
    drive(1'b1, 1'b0, 32'h44, 1'b1, 1'b0); cycle();
    chk("t4_valid", 64'(bus.ou_valid_one), 64'd1);
    chk("t4_head", 64'(bus.ou_data_one), 64'h44);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    cycle();
    chk("t4_empty", 64'(bus.ou_valid_one), 64'd0);

    // Test 5: reset discards buffered words.
    drive(1'b1, 1'b0, 32'hA1, 1'b0, 1'b0); cycle();
    drive(1'b1, 1'b0, 32'hA2, 1'b0, 1'b0); cycle();
    drive(1'b1, 1'b1, 32'hB1, 1'b0, 1'b0); cycle();
    drive(1'b1, 1'b1, 32'hB2, 1'b0, 1'b0); cycle();
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 32'hCC, 1'b1, 1'b1);
    cycle();
    rst_n = 1'b1;
    chk("t5_valid_one", 64'(bus.ou_valid_one), 64'd0);
    chk("t5_valid_two", 64'(bus.ou_valid_two), 64'd0);
    chk("t5_data_two", 64'(bus.ou_data_two), 64'd0);
    chk("t5_count_one", 64'(bus.ou_count_one), 64'd0);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
    cycle();
    chk("t5_no_delivery", 64'(bus.ou_count_two), 64'd0);

    // Random traffic against the model, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      drive(1'($urandom), 1'($urandom), $urandom, 1'($urandom), 1'($urandom));
      cycle();
    end
    rst_n = 1'b1;

    // Test 6: 65536 deliveries on output one wrap the counter to zero.
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      drive(1'b1, 1'b0, $urandom, 1'b1, 1'b0);
      cycle();
    end
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    cycle();
    chk("t6_wrap", 64'(bus.ou_count_one), 64'd0);
    chk("t6_drained", 64'(bus.ou_valid_one), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
